// File: rtl/alu_sched_if.sv
// alu_sched_if
// Bundles the signals around the shared-ALU scheduler: two request
// channels, the tagged response channel and the bus to the external ALU.
//
// Signals
//   req0_*/req1_*   valid, ready, op[2:0], a[31:0], b[31:0] per requester
//   rsp_*           valid, ready, id, data[31:0], flags[3:0] = {ZF,VF,CF,NF}
//   alu_din1/2      ALU operands, alu_control ALU op code
//   alu_run         ALU output enable (low = ALU drives alu_dout)
//   alu_dout        ALU result bus, alu_zf/vf/cf/nf ALU flags
//
// Modports
//   slave   the scheduler itself
//   master  requesters, response consumer and ALU (the environment)
interface alu_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;

    logic [31:0] alu_din1;
    logic [31:0] alu_din2;
    logic [2:0]  alu_control;
    logic        alu_run;
    logic [31:0] alu_dout;
    logic        alu_zf;
    logic        alu_vf;
    logic        alu_cf;
    logic        alu_nf;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready,
        output alu_din1, alu_din2, alu_control, alu_run,
        input  alu_dout, alu_zf, alu_vf, alu_cf, alu_nf
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready,
        input  alu_din1, alu_din2, alu_control, alu_run,
        output alu_dout, alu_zf, alu_vf, alu_cf, alu_nf
    );
endinterface

// File: rtl/alu_sched.sv
// alu_sched
// Round-robin scheduler sharing one 16-bit ALU between two requesters.
// One operation is accepted at a time, issued to the ALU, held while the
// result settles, captured, and returned on a response channel tagged with
// the requester ID. Op 000 returns the last captured result without
// touching the ALU.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   bus            alu_sched_if.slave (requests, response, ALU bus)
//   perf_ops       completed responses, wrapping (ALU_SCHED_PERF_EN only)
//   perf_stall     RESP cycles with rsp_ready low, saturating
//                  (ALU_SCHED_PERF_EN only)
//
// Parameters
//   SETTLE_CYCLES  cycles the ALU output is enabled before capture (1..15)
//
// Build option
//   ALU_SCHED_PERF_EN  define to add the performance counters
module alu_sched #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        lastGrant_q;
    logic [3:0]  settleCnt_q;
    logic [31:0] aluA_q;
    logic [31:0] aluB_q;
    logic [2:0]  aluCtl_q;
    logic        rspId_q;
    logic [31:0] lastData_q;
    logic [3:0]  lastFlags_q;

    logic        grant0;
    logic        grant1;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        acceptId;
    logic [2:0]  acceptOp;
    logic [31:0] acceptA;
    logic [31:0] acceptB;
    logic        settleDone;

    // With both requesters valid the one not granted last wins; lastGrant_q
    // resets to 1 so req0 is favoured first.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || lastGrant_q);
        grant1 = bus.req1_valid && !grant0;
    end

    assign ready0 = (state_q == IDLE) && grant0;
    assign ready1 = (state_q == IDLE) && grant1;

    assign accept   = ready0 || ready1;
    assign acceptId = ready1;
    assign acceptOp = ready1 ? bus.req1_op : bus.req0_op;
    assign acceptA  = ready1 ? bus.req1_a  : bus.req0_a;
    assign acceptB  = ready1 ? bus.req1_b  : bus.req0_b;

    assign settleDone = (state_q == SETTLE) && (settleCnt_q == 4'd0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (acceptOp == 3'b000) ? RESP : ISSUE;
                end
            end
            ISSUE:  state_d = SETTLE;
            SETTLE: begin
                if (settleDone) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/control registers only load on real ALU ops, so the ALU keeps
    // seeing the last issued op and a re-read never selects its 000 path.
    // lastData_q/lastFlags_q double as the response payload: a re-read
    // simply presents them again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= 1'b1;
            settleCnt_q <= 4'd0;
            aluA_q      <= 32'd0;
            aluB_q      <= 32'd0;
            aluCtl_q    <= 3'b000;
            rspId_q     <= 1'b0;
            lastData_q  <= 32'd0;
            lastFlags_q <= 4'd0;
        end else begin
            if (accept) begin
                rspId_q     <= acceptId;
                lastGrant_q <= acceptId;
                if (acceptOp != 3'b000) begin
                    aluA_q   <= acceptA;
                    aluB_q   <= acceptB;
                    aluCtl_q <= acceptOp;
                end
            end

            if (state_q == ISSUE) begin
                settleCnt_q <= 4'(SETTLE_CYCLES - 1);
            end else if ((state_q == SETTLE) && (settleCnt_q != 4'd0)) begin
                settleCnt_q <= settleCnt_q - 4'd1;
            end

            if (settleDone) begin
                lastData_q  <= bus.alu_dout;
                lastFlags_q <= {bus.alu_zf, bus.alu_vf, bus.alu_cf, bus.alu_nf};
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rspId_q;
    assign bus.rsp_data    = lastData_q;
    assign bus.rsp_flags   = lastFlags_q;
    assign bus.alu_din1    = aluA_q;
    assign bus.alu_din2    = aluB_q;
    assign bus.alu_control = aluCtl_q;
    // The ALU output is enabled only while the result settles.
    assign bus.alu_run     = (state_q != SETTLE);

`ifdef ALU_SCHED_PERF_EN
    logic [15:0] perfOps_q;
    logic [15:0] perfStall_q;

    // perf_ops wraps naturally; perf_stall holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfOps_q   <= 16'd0;
            perfStall_q <= 16'd0;
        end else begin
            if ((state_q == RESP) && bus.rsp_ready) begin
                perfOps_q <= perfOps_q + 16'd1;
            end
            if ((state_q == RESP) && !bus.rsp_ready && (perfStall_q != 16'hFFFF)) begin
                perfStall_q <= perfStall_q + 16'd1;
            end
        end
    end

    assign perf_ops   = perfOps_q;
    assign perf_stall = perfStall_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched
// Self-checking bench for alu_sched with SETTLE_CYCLES=1. A behavioural
// 16-bit ALU drives alu_dout only while alu_run is low and a poison value
// otherwise. Directed vectors live in a table; arbitration, backpressure
// and mid-operation reset are hand-written sequences.
module tb_alu_sched;

    logic clk;
    logic rst;

    alu_sched_if bus ();

`ifdef ALU_SCHED_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;
`endif

    alu_sched #(
        .SETTLE_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALU_SCHED_PERF_EN
        ,
        .perf_ops(perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: result sign-extended from 16 bits, flags raw.
    logic [15:0] mA;
    logic [15:0] mB;
    logic [15:0] mR;
    logic [16:0] mSum;
    logic        mC;
    logic        mV;

    always_comb begin
        mA   = bus.alu_din1[15:0];
        mB   = bus.alu_din2[15:0];
        mSum = 17'd0;
        mR   = 16'd0;
        mC   = 1'b0;
        mV   = 1'b0;
        case (bus.alu_control)
            3'b001: begin
                mSum = {1'b0, mA} + {1'b0, mB};
                mR   = mSum[15:0];
                mC   = mSum[16];
                mV   = (mA[15] == mB[15]) && (mR[15] != mA[15]);
            end
            3'b010: begin
                mR = mA - mB;
                mC = (mA < mB);
                mV = (mA[15] != mB[15]) && (mR[15] != mA[15]);
            end
            3'b011:          mR = mA & mB;
            3'b100:          mR = mA | mB;
            3'b101:          mR = mA ^ mB;
            3'b110, 3'b111:  mR = mA << mB[3:0];
            default:         mR = 16'd0;
        endcase
        if (bus.alu_run) begin
            bus.alu_dout = 32'hDEADBEEF;
            bus.alu_zf   = 1'b1;
            bus.alu_vf   = 1'b1;
            bus.alu_cf   = 1'b1;
            bus.alu_nf   = 1'b1;
        end else begin
            bus.alu_dout = {{16{mR[15]}}, mR};
            bus.alu_zf   = (mR == 16'd0);
            bus.alu_vf   = mV;
            bus.alu_cf   = mC;
            bus.alu_nf   = mR[15];
        end
    end

    // Count cycles with the ALU output enabled.
    int runLowCnt = 0;
    always @(negedge clk) begin
        if (!bus.alu_run) begin
            runLowCnt <= runLowCnt + 1;
        end
    end

    int assertions = 0;
    int failures   = 0;
    int doneCount  = 0;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expData;
        logic [3:0]  expFlags;
        int          expLat;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertions++;
        failures++;
        $display("[TB] FAIL %s: actual no DUT event within bound, required event", name);
    endtask

    task automatic dropValids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Presents one request, waits for its handshake and then for rsp_valid.
    // latency counts edges from the accept edge (inclusive) to rsp_valid.
    task automatic applyStimulus(input logic id, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output int latency, output int runLow);
        int waitCnt;
        int startLow;
        latency = -1;
        runLow  = -1;
        @(negedge clk);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
        #1;
        waitCnt = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && waitCnt < 20) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (waitCnt >= 20) begin
            reportTimeout("accept");
            dropValids();
            return;
        end
        @(posedge clk);
        #1;
        dropValids();
        startLow = runLowCnt;
        latency  = 1;
        while (!bus.rsp_valid && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
        if (!bus.rsp_valid) begin
            reportTimeout("rsp_valid");
        end
        runLow = runLowCnt - startLow;
    endtask

    initial begin
        int lat;
        int runLow;
        int waitCnt;
        logic [2:0]  expCtl;
        logic [31:0] expDin1;
        logic [31:0] expDin2;
        logic        expGrant[4];
        logic [31:0] expArbData[4];

        vecs[0] = '{1'b0, 3'b001, 32'h0000_6075, 32'h0000_5105, 32'hFFFF_B17A, 4'b0101, 3};
        vecs[1] = '{1'b1, 3'b010, 32'h0000_1F75, 32'h0000_108A, 32'h0000_0EEB, 4'b0000, 3};
        vecs[2] = '{1'b1, 3'b011, 32'h0000_1F75, 32'h0000_108A, 32'h0000_1000, 4'b0000, 3};
        vecs[3] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0000_1000, 4'b0000, 1};
        vecs[4] = '{1'b0, 3'b100, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 4'b0000, 3};
        vecs[5] = '{1'b1, 3'b101, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b1000, 3};
        vecs[6] = '{1'b0, 3'b010, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0011, 3};
        vecs[7] = '{1'b1, 3'b110, 32'hABCD_0001, 32'h0000_0004, 32'h0000_0010, 4'b0000, 3};
        vecs[8] = '{1'b0, 3'b111, 32'h0000_8001, 32'h0000_0001, 32'h0000_0002, 4'b0000, 3};
        vecs[9] = '{1'b1, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 4'b0000, 1};

        expGrant   = '{1'b0, 1'b1, 1'b0, 1'b1};
        expArbData = '{32'h0000_0002, 32'h0000_0011, 32'h0000_0002, 32'h0000_0011};

        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_op    = 3'b000;
        bus.req0_a     = 32'd0;
        bus.req0_b     = 32'd0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 3'b000;
        bus.req1_a     = 32'd0;
        bus.req1_b     = 32'd0;
        bus.rsp_ready  = 1'b1;

        // Reset state
        #2;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("reset_rsp_data", bus.rsp_data, 32'd0);
        checkOutput("reset_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        checkOutput("reset_alu_din1", bus.alu_din1, 32'd0);
        checkOutput("reset_alu_din2", bus.alu_din2, 32'd0);
        checkOutput("reset_alu_control", 32'(bus.alu_control), 32'd0);
        checkOutput("reset_alu_run", 32'(bus.alu_run), 32'd1);
        checkOutput("reset_ready0", 32'(bus.req0_ready), 32'd0);
        checkOutput("reset_ready1", 32'(bus.req1_ready), 32'd0);
`ifdef ALU_SCHED_PERF_EN
        checkOutput("reset_perf_ops", 32'(perf_ops), 32'd0);
        checkOutput("reset_perf_stall", 32'(perf_stall), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        expCtl  = 3'b000;
        expDin1 = 32'd0;
        expDin2 = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op != 3'b000) begin
                expCtl  = vecs[i].op;
                expDin1 = vecs[i].a;
                expDin2 = vecs[i].b;
            end
            applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, lat, runLow);
            doneCount++;
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("v%0d_rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].id));
            checkOutput($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].expData);
            checkOutput($sformatf("v%0d_rsp_flags", i), 32'(bus.rsp_flags), 32'(vecs[i].expFlags));
            checkOutput($sformatf("v%0d_alu_run_low_cycles", i), 32'(runLow),
                        (vecs[i].op == 3'b000) ? 32'd0 : 32'd1);
            checkOutput($sformatf("v%0d_alu_control", i), 32'(bus.alu_control), 32'(expCtl));
            checkOutput($sformatf("v%0d_alu_din1", i), bus.alu_din1, expDin1);
            checkOutput($sformatf("v%0d_alu_din2", i), bus.alu_din2, expDin2);
        end

        // Arbitration: both requesters valid for four ops
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b001;
        bus.req0_a     = 32'h1;
        bus.req0_b     = 32'h1;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b100;
        bus.req1_a     = 32'h10;
        bus.req1_b     = 32'h01;
        for (int k = 0; k < 4; k++) begin
            #1;
            waitCnt = 0;
            while (!(bus.req0_ready || bus.req1_ready) && waitCnt < 20) begin
                @(negedge clk);
                #1;
                waitCnt++;
            end
            if (waitCnt >= 20) begin
                reportTimeout($sformatf("arb%0d_grant", k));
                break;
            end
            checkOutput($sformatf("arb%0d_grant", k), 32'(bus.req1_ready), 32'(expGrant[k]));
            checkOutput($sformatf("arb%0d_onehot", k), 32'(bus.req0_ready && bus.req1_ready), 32'd0);
            @(posedge clk);
            #1;
            lat = 1;
            while (!bus.rsp_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            doneCount++;
            checkOutput($sformatf("arb%0d_rsp_id", k), 32'(bus.rsp_id), 32'(expGrant[k]));
            checkOutput($sformatf("arb%0d_rsp_data", k), bus.rsp_data, expArbData[k]);
            @(negedge clk);
        end
        dropValids();
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        // Backpressure: hold the response for five cycles
        applyStimulus(1'b0, 3'b001, 32'h3, 32'h4, lat, runLow);
        doneCount++;
        checkOutput("bp_latency", 32'(lat), 32'd3);
        checkOutput("bp_rsp_data", bus.rsp_data, 32'h0000_0007);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b001;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b010;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_rsp_valid", s), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("bp%0d_rsp_data", s), bus.rsp_data, 32'h0000_0007);
            checkOutput($sformatf("bp%0d_rsp_id", s), 32'(bus.rsp_id), 32'd0);
            checkOutput($sformatf("bp%0d_rsp_flags", s), 32'(bus.rsp_flags), 32'd0);
            checkOutput($sformatf("bp%0d_ready0", s), 32'(bus.req0_ready), 32'd0);
            checkOutput($sformatf("bp%0d_ready1", s), 32'(bus.req1_ready), 32'd0);
        end
`ifdef ALU_SCHED_PERF_EN
        checkOutput("bp_perf_stall", 32'(perf_stall), 32'd5);
        checkOutput("bp_perf_ops_before", 32'(perf_ops), 32'(doneCount - 1));
`endif
        dropValids();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_SCHED_PERF_EN
        checkOutput("bp_perf_ops_after", 32'(perf_ops), 32'(doneCount));
        checkOutput("bp_perf_stall_after", 32'(perf_stall), 32'd5);
`endif

        // Mid-operation reset during SETTLE
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b001;
        bus.req1_a     = 32'h5;
        bus.req1_b     = 32'h6;
        #1;
        waitCnt = 0;
        while (!bus.req1_ready && waitCnt < 20) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (waitCnt >= 20) begin
            reportTimeout("midreset_accept");
        end
        @(posedge clk);
        #1;
        dropValids();
        @(posedge clk);
        #1;
        checkOutput("midreset_in_settle_alu_run", 32'(bus.alu_run), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_alu_run", 32'(bus.alu_run), 32'd1);
        checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midreset_rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("midreset_rsp_data", bus.rsp_data, 32'd0);
        checkOutput("midreset_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        checkOutput("midreset_alu_din1", bus.alu_din1, 32'd0);
        checkOutput("midreset_alu_din2", bus.alu_din2, 32'd0);
        checkOutput("midreset_alu_control", 32'(bus.alu_control), 32'd0);
`ifdef ALU_SCHED_PERF_EN
        checkOutput("midreset_perf_ops", 32'(perf_ops), 32'd0);
        checkOutput("midreset_perf_stall", 32'(perf_stall), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // After reset the pointer favours req0 again
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b001;
        bus.req0_a     = 32'h5;
        bus.req0_b     = 32'h6;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b010;
        bus.req1_a     = 32'h9;
        bus.req1_b     = 32'h1;
        #1;
        checkOutput("postreset_ready0", 32'(bus.req0_ready), 32'd1);
        checkOutput("postreset_ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        dropValids();
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("postreset_latency", 32'(lat), 32'd3);
        checkOutput("postreset_rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("postreset_rsp_data", bus.rsp_data, 32'h0000_000B);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares the single 16-bit ALU between two requesters, typically the execute stage and the address/branch unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand and control inputs, and holds them stable while the result settles. It then captures the sign-extended result and the ZF/VF/CF/NF flags and returns them on a response channel tagged with the requester ID.

## Interface
- SETTLE_CYCLES, 1, cycles the ALU output is enabled (alu_run low) before capture; legal range 1–15.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_op / req1_op  in  3  ALU control code: 001 add, 010 sub, 011 and, 100 or, 101 xor, 110/111 shift-left; 000 means re-read the last result.
- req0_a / req1_a, req0_b / req1_b  in  32  operands; only bits [15:0] are used by the ALU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the op (0 or 1).
- rsp_data  out  32  captured ALU result.
- rsp_flags  out  4  {ZF,VF,CF,NF} as captured.
- alu_din1, alu_din2  out  32  ALU operands.
- alu_control  out  3  ALU control.
- alu_run  out  1  ALU output enable; low drives alu_dout, high floats it.
- alu_dout  in  32  ALU result bus.
- alu_zf, alu_vf, alu_cf, alu_nf  in  1  ALU flags.

## Operation
- States are IDLE, ISSUE, SETTLE and RESP.
- **IDLE**
  - The grant goes to one valid requester by round-robin. With both valid, the grant goes to the one not granted last; after reset the pointer favours req0.
  - Only the granted requester sees ready=1. Ready is combinational: state==IDLE && grant.
  - On a handshake edge, the op, operands and ID are latched into internal registers.
  - If op≠000, go to ISSUE. If op==000, go straight to RESP with rsp_data/rsp_flags equal to the last captured values; the ALU is not touched.
- **ISSUE** (1 cycle): drive alu_din1/2 and alu_control from the latched registers, alu_run=1. Go to SETTLE.
- **SETTLE** (SETTLE_CYCLES cycles)
  - alu_run=0; operands and control stay unchanged.
  - At the edge ending the last SETTLE cycle, capture alu_dout into rsp_data and {alu_zf,alu_vf,alu_cf,alu_nf} into rsp_flags. These also update the last-result registers. Go to RESP.
- **RESP**: rsp_valid=1. rsp_data, rsp_flags and rsp_id stay stable until rsp_ready. On the rsp_valid&&rsp_ready edge, go to IDLE. No new request is accepted in this state.
- Outside ISSUE/SETTLE:
  - alu_run=1.
  - alu_control keeps the last issued op, so the ALU's 000 feedback path is never selected mid-operation.
  - alu_din1/2 keep the last value.
- Flags are passed through raw; no reinterpretation by op.

## Timing
- Reset values:
  - State IDLE; both ready=0 until the first evaluation.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0.
  - alu_din1=alu_din2=0, alu_control=000, alu_run=1.
  - Last-result registers 0; round-robin pointer favours req0.
- Latency from accept edge to rsp_valid high: 2+SETTLE_CYCLES edges for ALU ops, 1 edge for op 000.
- Minimum issue interval with rsp_ready tied high: 3+SETTLE_CYCLES cycles.
- Request valid dropped before the handshake: no effect, nothing is latched.
- Reset asserted in any state: immediate return to IDLE. An in-flight op is discarded with no response; the pointer resets.
- rsp_ready asserted outside RESP: ignored.

## Configuration
- ALU_SCHED_PERF_EN, when defined, adds outputs perf_ops[15:0] and perf_stall[15:0].
  - perf_ops: completed responses, wrapping at 0xFFFF→0.
  - perf_stall: cycles in RESP with rsp_ready=0, saturating at 0xFFFF.
  - Both counters reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- ADD:
  - Stimulus: req0 op=001, a=0x6075, b=0x5105, SETTLE_CYCLES=1, rsp_ready=1.
  - Required: rsp_valid 3 edges after accept, rsp_data=0xFFFFB17A, NF=1, VF=1, ZF=0, rsp_id=0.
- SUB then AND:
  - Stimulus: req1 op=010, a=0x1F75, b=0x108A, then op=011 with the same operands.
  - Required: rsp_data=0x00000EEB with ZF=0/NF=0, then 0x00001000; alu_run low exactly one cycle per op.
- Re-read:
  - Stimulus: op=000 immediately after the AND.
  - Required: rsp_valid on the next edge, rsp_data=0x00001000, flags equal to the AND's; alu_run stays 1.
- Arbitration:
  - Stimulus: both requesters hold valid continuously for 4 ops.
  - Required: grants 0,1,0,1 and rsp_id sequence 0,1,0,1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_* stable, both ready=0; with PERF_EN, perf_stall=5 and perf_ops increments by 1 on release.
- Mid-op reset:
  - Stimulus: rst pulsed during SETTLE.
  - Required: alu_run=1, rsp_valid=0, all outputs at reset values without waiting for a clock edge; the next request is accepted normally from req0.
